card_dealer: RTL and testbench
==============================

// Module: card_dealer
// PURPOSE
//  Downstream consumer of the free-running Counter value: on a draw request from the
//  game FSM, turns the count into a card rank (1..13), checks it against a per-rank
//  inventory of the shoe, linear-probes to the next available rank if exhausted, and
//  returns rank and BlackJack points. Sits between Counter (entropy) and the game FSM.
// PARAMETERS
//  WIDTH  12  width of i_Count (matches Counter WIDTH)
//  DECKS  1   decks in the shoe; each rank starts with 4*DECKS cards
//  localparam CNT_W = $clog2(4*DECKS+1), REM_W = $clog2(52*DECKS+1)
// PORTS
//  clk_50M      in   1      50 MHz system clock, sole clock
//  i_Reset_n    in   1      asynchronous, active-low reset
//  i_Count      in   WIDTH  Counter output, sampled as entropy (same clock domain)
//  i_Draw       in   1      draw request; sampled only in IDLE
//  i_Shuffle    in   1      synchronous restore of full shoe; aborts any draw
//  o_Card       out  4      last dealt rank, 1=Ace .. 13=King; holds until next deal
//  o_Points     out  4      points of o_Card: rank<10 -> rank, else 10 (Ace=1; FSM adds 10)
//  o_Valid      out  1      one-cycle pulse: o_Card/o_Points newly updated
//  o_Busy       out  1      high while not in IDLE
//  o_Empty      out  1      high when o_Remaining == 0
//  o_Remaining  out  REM_W  cards left in shoe
// BEHAVIOUR
//  Reset (async, i_Reset_n=0): all 13 rank counts = 4*DECKS; o_Remaining = 52*DECKS;
//   o_Card=0, o_Points=0, o_Valid=0, o_Busy=0, o_Empty=0; state=IDLE. Reset mid-draw
//   aborts it with no o_Valid.
//  FSM: IDLE, CHECK.
//   IDLE: i_Shuffle -> refill, stay IDLE. Else i_Draw & !o_Empty -> latch
//    rank_r = (i_Count % 13) + 1, probes_r=0, go CHECK. i_Draw & o_Empty -> ignored.
//   CHECK: i_Shuffle -> refill, IDLE, no o_Valid. Else if count[rank_r]!=0:
//    count[rank_r]--, o_Remaining--, o_Card<=rank_r, o_Points<=pts(rank_r), o_Valid<=1,
//    go IDLE. Else rank_r <= (rank_r==13) ? 1 : rank_r+1, stay CHECK.
//  Latency: i_Draw sampled at edge N; o_Valid high for the single cycle after edge
//   N+1+k, k = number of exhausted ranks probed (0..12). Never exceeds 12 probes since
//   draw only starts with o_Remaining>0.
//  i_Draw while o_Busy: ignored (not queued). i_Shuffle wins over i_Draw same cycle.
//  o_Empty is combinational from o_Remaining (or registered alongside it; same cycle).
//  Counts never underflow; o_Remaining == sum of rank counts at every edge.
//  Modulo: i_Count % 13 on the full WIDTH-bit unsigned value; bias is accepted.
// STRUCTURE
//  blackjack_pkg: N_RANKS=13, SUITS=4, RANK_ACE=1, RANK_TEN=10, RANK_KING=13,
//   function card_points(rank) -> 4-bit points; shared with the game FSM.
//  Sub-module rank_inventory: 13 x CNT_W counters + remaining counter; ports
//   refill, dec_en, dec_rank, rd_rank -> rd_avail, remaining. card_dealer keeps FSM,
//   modulo, probe wrap and output registers.
// TESTING
//  1 Release reset -> o_Remaining=52, o_Empty=0, o_Card=0, o_Valid=0, o_Busy=0.
//  2 i_Count=0, pulse i_Draw -> o_Valid one cycle 2 clocks later, o_Card=1, o_Points=1,
//    o_Remaining=51. i_Count=25 -> o_Card=13, o_Points=10; i_Count=4095 -> o_Card=0x4+1=
//    (4095%13)+1=1.
//  3 Five draws with i_Count=3: first four o_Card=4 (latency 2); fifth o_Card=5,
//    latency 3 (one probe). Ranks 11,12,13 exhausted, draw at 13 -> wraps, o_Card=1.
//  4 52 draws -> o_Empty=1, o_Remaining=0, each rank dealt exactly 4; 53rd i_Draw ->
//    no o_Valid, o_Busy stays 0.
//  5 i_Shuffle asserted in same cycle as i_Draw, and separately during a CHECK probe ->
//    no o_Valid, state IDLE, o_Remaining=52, all counts 4; o_Card unchanged.
//  6 i_Reset_n low mid-CHECK -> immediate reset values; i_Draw during o_Busy ignored.

Source files
------------

// File: rtl/blackjack_pkg.sv
// blackjack_pkg
//   Shared constants and helpers for the BlackJack datapath (card dealer and game FSM).
//   - Rank encoding: 1 = Ace .. 13 = King; 0 is "no card".
//   - card_points(): BlackJack points of a rank, with Ace counted as 1 (the game FSM
//     decides when an Ace is worth 11).
//   - dealer_state_e: card dealer FSM state encoding.
package blackjack_pkg;

    localparam int unsigned N_RANKS = 13;
    localparam int unsigned SUITS   = 4;

    localparam logic [3:0] RANK_ACE  = 4'd1;
    localparam logic [3:0] RANK_TEN  = 4'd10;
    localparam logic [3:0] RANK_KING = 4'd13;

    typedef enum logic [0:0] {
        StIdle,
        StCheck
    } dealer_state_e;

    // Ranks below ten score face value; ten and the court cards all score ten.
    function automatic logic [3:0] card_points(input logic [3:0] rank);
        return (rank < RANK_TEN) ? rank : RANK_TEN;
    endfunction

endpackage

// File: rtl/rank_inventory.sv
// rank_inventory
//   Per-rank card counts of the shoe plus a running total of cards left.
//   Ports:
//     clk_i         clock
//     rst_ni        asynchronous active-low reset (loads a full shoe)
//     refill_i      synchronous restore of a full shoe; overrides dec_en_i
//     dec_en_i      remove one card of rank dec_rank_i
//     dec_rank_i    rank to remove (1..13)
//     rd_rank_i     rank to query (1..13)
//     rd_avail_o    at least one card of rd_rank_i is left
//     remaining_o   total cards left (always the sum of the per-rank counts)
module rank_inventory
    import blackjack_pkg::*;
#(
    parameter int unsigned DECKS = 1,
    parameter int unsigned CNT_W = $clog2(4 * DECKS + 1),
    parameter int unsigned REM_W = $clog2(52 * DECKS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             refill_i,
    input  logic             dec_en_i,
    input  logic [3:0]       dec_rank_i,
    input  logic [3:0]       rd_rank_i,
    output logic             rd_avail_o,
    output logic [REM_W-1:0] remaining_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SUITS * DECKS);
    localparam logic [REM_W-1:0] FULL_REM = REM_W'(N_RANKS * SUITS * DECKS);

    logic [CNT_W-1:0] cnt_q [N_RANKS];
    logic [CNT_W-1:0] cnt_d [N_RANKS];
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_d;

    logic       dec_in_range;
    logic       rd_in_range;
    logic [3:0] dec_idx;
    logic [3:0] rd_idx;

    // Ranks are 1-based; storage is 0-based.
    assign dec_idx      = dec_rank_i - RANK_ACE;
    assign rd_idx       = rd_rank_i - RANK_ACE;
    assign dec_in_range = (dec_rank_i >= RANK_ACE) && (dec_rank_i <= RANK_KING);
    assign rd_in_range  = (rd_rank_i >= RANK_ACE) && (rd_rank_i <= RANK_KING);

    assign rd_avail_o  = rd_in_range && (cnt_q[rd_idx] != '0);
    assign remaining_o = rem_q;

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        if (refill_i) begin
            for (int unsigned i = 0; i < N_RANKS; i++) begin
                cnt_d[i] = FULL_CNT;
            end
            rem_d = FULL_REM;
        end else if (dec_en_i && dec_in_range && (cnt_q[dec_idx] != '0)) begin
            // Decrement total and rank together so the sum invariant always holds.
            cnt_d[dec_idx] = cnt_q[dec_idx] - CNT_W'(1);
            rem_d          = rem_q - REM_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_RANKS; i++) begin
                cnt_q[i] <= FULL_CNT;
            end
            rem_q <= FULL_REM;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/card_dealer.sv
// card_dealer
//   Deals BlackJack cards from a finite shoe. A draw request turns the free-running
//   Counter value into a rank ((count % 13) + 1); if that rank is exhausted the dealer
//   steps to the next rank (King wraps to Ace), one rank per clock, until a card is found.
//   Ports:
//     clk_50M      system clock
//     i_Reset_n    asynchronous active-low reset (full shoe, outputs cleared)
//     i_Count      Counter value used as entropy
//     i_Draw       draw request, honoured only when idle and shoe not empty
//     i_Shuffle    restore full shoe; aborts a draw in progress
//     o_Card       last dealt rank (1..13), held until the next deal
//     o_Points     points of o_Card (Ace = 1, court cards = 10)
//     o_Valid      one-cycle pulse when o_Card/o_Points are updated
//     o_Busy       draw in progress
//     o_Empty      no cards left
//     o_Remaining  cards left in the shoe
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DECKS = 1,
    localparam int unsigned CNT_W = $clog2(4 * DECKS + 1),
    localparam int unsigned REM_W = $clog2(52 * DECKS + 1)
) (
    input  logic             clk_50M,
    input  logic             i_Reset_n,
    input  logic [WIDTH-1:0] i_Count,
    input  logic             i_Draw,
    input  logic             i_Shuffle,
    output logic [3:0]       o_Card,
    output logic [3:0]       o_Points,
    output logic             o_Valid,
    output logic             o_Busy,
    output logic             o_Empty,
    output logic [REM_W-1:0] o_Remaining
);

    dealer_state_e state_q, state_d;
    logic [3:0]    rank_q, rank_d;
    logic [3:0]    probes_q, probes_d;
    logic [3:0]    card_q, card_d;
    logic [3:0]    points_q, points_d;
    logic          valid_q, valid_d;

    logic             refill;
    logic             dec_en;
    logic             rd_avail;
    logic [REM_W-1:0] remaining;
    logic [3:0]       draw_rank;

    // Modulo on the full-width count; the small bias toward low ranks is accepted.
    assign draw_rank = 4'(i_Count % WIDTH'(N_RANKS)) + RANK_ACE;

    rank_inventory #(
        .DECKS (DECKS),
        .CNT_W (CNT_W),
        .REM_W (REM_W)
    ) u_rank_inventory (
        .clk_i       (clk_50M),
        .rst_ni      (i_Reset_n),
        .refill_i    (refill),
        .dec_en_i    (dec_en),
        .dec_rank_i  (rank_q),
        .rd_rank_i   (rank_q),
        .rd_avail_o  (rd_avail),
        .remaining_o (remaining)
    );

    always_comb begin
        state_d  = state_q;
        rank_d   = rank_q;
        probes_d = probes_q;
        card_d   = card_q;
        points_d = points_q;
        valid_d  = 1'b0;
        refill   = 1'b0;
        dec_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_Shuffle) begin
                    refill = 1'b1;
                end else if (i_Draw && (remaining != '0)) begin
                    rank_d   = draw_rank;
                    probes_d = 4'd0;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (i_Shuffle) begin
                    refill  = 1'b1;
                    state_d = StIdle;
                end else if (rd_avail) begin
                    dec_en   = 1'b1;
                    card_d   = rank_q;
                    points_d = card_points(rank_q);
                    valid_d  = 1'b1;
                    state_d  = StIdle;
                end else begin
                    // Shoe is non-empty on entry, so this terminates within 12 steps.
                    rank_d   = (rank_q == RANK_KING) ? RANK_ACE : rank_q + 4'd1;
                    probes_d = probes_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50M or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= StIdle;
            rank_q   <= RANK_ACE;
            probes_q <= 4'd0;
            card_q   <= 4'd0;
            points_q <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rank_q   <= rank_d;
            probes_q <= probes_d;
            card_q   <= card_d;
            points_q <= points_d;
            valid_q  <= valid_d;
        end
    end

    assign o_Card      = card_q;
    assign o_Points    = points_q;
    assign o_Valid     = valid_q;
    assign o_Busy      = (state_q != StIdle);
    assign o_Empty     = (remaining == '0);
    assign o_Remaining = remaining;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer
//   Self-checking bench for card_dealer against a shoe model kept as an array of
//   per-rank counts; expected rank and latency come from walking that array.
module tb_card_dealer;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned DECKS = 1;
    localparam int unsigned REM_W = $clog2(52 * DECKS + 1);

    logic             clk_50M = 1'b0;
    logic             i_Reset_n;
    logic [WIDTH-1:0] i_Count;
    logic             i_Draw;
    logic             i_Shuffle;
    logic [3:0]       o_Card;
    logic [3:0]       o_Points;
    logic             o_Valid;
    logic             o_Busy;
    logic             o_Empty;
    logic [REM_W-1:0] o_Remaining;

    always #10 clk_50M = ~clk_50M;

    card_dealer #(
        .WIDTH (WIDTH),
        .DECKS (DECKS)
    ) dut (
        .clk_50M     (clk_50M),
        .i_Reset_n   (i_Reset_n),
        .i_Count     (i_Count),
        .i_Draw      (i_Draw),
        .i_Shuffle   (i_Shuffle),
        .o_Card      (o_Card),
        .o_Points    (o_Points),
        .o_Valid     (o_Valid),
        .o_Busy      (o_Busy),
        .o_Empty     (o_Empty),
        .o_Remaining (o_Remaining)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Shoe model: cards left per rank (index 1..13) and in total.
    int mcnt [1:13];
    int mrem;
    int dealt [1:13];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_refill();
        for (int r = 1; r <= 13; r++) mcnt[r] = 4 * DECKS;
        mrem = 52 * DECKS;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_rem"},   32'(o_Remaining), 32'(52 * DECKS));
        check_eq({tag, "_empty"}, 32'(o_Empty),  0);
        check_eq({tag, "_card"},  32'(o_Card),   0);
        check_eq({tag, "_pts"},   32'(o_Points), 0);
        check_eq({tag, "_valid"}, 32'(o_Valid),  0);
        check_eq({tag, "_busy"},  32'(o_Busy),   0);
    endtask

    // One complete draw; spam re-asserts i_Draw while busy, which must be ignored.
    task automatic do_draw(input int cnt_val, input bit spam);
        int  r;
        int  probes;
        int  lat;
        bit  seen;
        r = (cnt_val % 13) + 1;
        probes = 0;
        while (mcnt[r] == 0 && probes < 13) begin
            r = (r % 13) + 1;
            probes++;
        end
        i_Count = WIDTH'(cnt_val);
        i_Draw  = 1'b1;
        step();
        i_Draw = spam;
        check_eq("draw_busy", 32'(o_Busy), 1);
        lat  = 1;
        seen = 1'b0;
        while (lat < 20 && !seen) begin
            step();
            i_Draw = 1'b0;
            lat++;
            if (o_Valid) seen = 1'b1;
        end
        check_eq("draw_valid_seen", 32'(seen), 1);
        check_eq("draw_latency", 32'(lat), 32'(2 + probes));
        check_eq("draw_card", 32'(o_Card), 32'(r));
        check_eq("draw_points", 32'(o_Points), 32'((r < 10) ? r : 10));
        mcnt[r]--;
        mrem--;
        check_eq("draw_remaining", 32'(o_Remaining), 32'(mrem));
        check_eq("draw_empty", 32'(o_Empty), 32'(mrem == 0));
        if (o_Card >= 1 && o_Card <= 13) dealt[o_Card]++;
        step();
        check_eq("valid_pulse_end", 32'(o_Valid), 0);
        check_eq("idle_after_draw", 32'(o_Busy), 0);
    endtask

    task automatic do_shuffle();
        i_Shuffle = 1'b1;
        step();
        i_Shuffle = 1'b0;
        model_refill();
    endtask

    initial begin
        logic [3:0] card_prev;
        int         vcount;

        i_Reset_n = 1'b0;
        i_Count   = '0;
        i_Draw    = 1'b0;
        i_Shuffle = 1'b0;
        model_refill();
        for (int r = 1; r <= 13; r++) dealt[r] = 0;
        #35;
        check_reset_values("in_reset");
        @(negedge clk_50M);
        i_Reset_n = 1'b1;
        step();
        check_reset_values("after_reset");

        // Basic rank mapping, including the full-scale count.
        do_draw(0, 1'b0);
        do_draw(25, 1'b0);
        do_draw(4095, 1'b0);

        // Exhaust rank 4, the fifth draw probes once to rank 5.
        do_shuffle();
        for (int i = 0; i < 5; i++) do_draw(3, 1'b0);

        // Exhaust 11..13, then a draw at King wraps to Ace.
        do_shuffle();
        for (int r = 10; r <= 12; r++) begin
            for (int i = 0; i < 4; i++) do_draw(r, 1'b0);
        end
        do_draw(12, 1'b0);

        // Random draws with random busy-time draw requests.
        do_shuffle();
        for (int i = 0; i < 30; i++) do_draw(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));

        // Empty the whole shoe.
        do_shuffle();
        for (int r = 1; r <= 13; r++) dealt[r] = 0;
        for (int i = 0; i < 52; i++) do_draw(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
        check_eq("empty_flag", 32'(o_Empty), 1);
        check_eq("empty_remaining", 32'(o_Remaining), 0);
        for (int r = 1; r <= 13; r++) check_eq($sformatf("dealt_rank%0d", r), 32'(dealt[r]), 4);

        // Draw on an empty shoe is ignored.
        card_prev = o_Card;
        i_Count = 12'd7;
        i_Draw  = 1'b1;
        step();
        i_Draw = 1'b0;
        check_eq("empty_draw_busy", 32'(o_Busy), 0);
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_Valid) vcount++;
            step();
        end
        check_eq("empty_draw_no_valid", 32'(vcount), 0);
        check_eq("empty_draw_card", 32'(o_Card), 32'(card_prev));

        // Shuffle and draw in the same cycle: shuffle wins.
        i_Count   = 12'd5;
        i_Draw    = 1'b1;
        i_Shuffle = 1'b1;
        step();
        i_Draw    = 1'b0;
        i_Shuffle = 1'b0;
        model_refill();
        check_eq("shuf_draw_busy", 32'(o_Busy), 0);
        check_eq("shuf_draw_valid", 32'(o_Valid), 0);
        check_eq("shuf_draw_rem", 32'(o_Remaining), 52);
        check_eq("shuf_draw_empty", 32'(o_Empty), 0);
        check_eq("shuf_draw_card", 32'(o_Card), 32'(card_prev));
        step();
        check_eq("shuf_draw_valid2", 32'(o_Valid), 0);

        // Shuffle during a probe aborts the draw.
        for (int i = 0; i < 4; i++) do_draw(0, 1'b0);
        card_prev = o_Card;
        i_Count = 12'd0;
        i_Draw  = 1'b1;
        step();
        i_Draw    = 1'b0;
        i_Shuffle = 1'b1;
        step();
        i_Shuffle = 1'b0;
        model_refill();
        check_eq("shuf_probe_busy", 32'(o_Busy), 0);
        check_eq("shuf_probe_valid", 32'(o_Valid), 0);
        check_eq("shuf_probe_rem", 32'(o_Remaining), 52);
        check_eq("shuf_probe_card", 32'(o_Card), 32'(card_prev));
        step();
        check_eq("shuf_probe_valid2", 32'(o_Valid), 0);
        // Rank 1 must be fully restored: four direct hits without probing.
        for (int i = 0; i < 4; i++) do_draw(0, 1'b0);

        // Asynchronous reset in the middle of a probe.
        i_Count = 12'd0;
        i_Draw  = 1'b1;
        step();
        i_Draw = 1'b0;
        check_eq("mid_reset_pre_busy", 32'(o_Busy), 1);
        i_Reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk_50M);
        i_Reset_n = 1'b1;
        model_refill();
        step();
        check_reset_values("post_mid_reset");

        // Busy-time draw requests after reset are still ignored.
        for (int i = 0; i < 10; i++) do_draw(int'($urandom_range(0, 4095)), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
